// File: rtl/posit_decode_pipe_if.sv
// posit_decode_pipe_if: input and output stream bundle of the posit decoder
interface posit_decode_pipe_if #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int TAG_W = 8
);
  localparam int SCALE_W = $clog2((NBITS-1) << ES) + 1;
  localparam int FRAC_W  = NBITS - ES - 3;
  logic                      in_valid;
  logic                      in_ready;
  logic [NBITS-1:0]          in_data;
  logic [TAG_W-1:0]          in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sign;
  logic                      out_zero;
  logic                      out_inf;
  logic signed [SCALE_W-1:0] out_scale;
  logic [FRAC_W-1:0]         out_frac;
  logic [NBITS-2:0]          out_abs;
  logic [TAG_W-1:0]          out_tag;
  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac, out_abs, out_tag
  );
  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_inf, out_scale, out_frac, out_abs, out_tag
  );
endinterface

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: three-stage posit(NBITS, ES) decoder with valid/ready and tag passthrough
module posit_decode_pipe #(
  parameter int NBITS = 32,
  parameter int ES    = 3,
  parameter int TAG_W = 8
) (
  input logic clk,
  input logic reset,
  posit_decode_pipe_if.slave io
);
  localparam int SCALE_W = $clog2((NBITS-1) << ES) + 1;
  localparam int RW      = NBITS - 1;
  localparam int MW      = $clog2(NBITS) + 1;
  logic               en;
  logic               v1, s1, z1, n1;
  logic [RW-1:0]      u1;
  logic [TAG_W-1:0]   t1;
  logic               v2, s2, z2, n2;
  logic [RW-1:0]      r2;
  logic [SCALE_W-1:0] k2;
  logic [MW-1:0]      w2;
  logic [TAG_W-1:0]   t2;
  logic [MW-1:0]      m, w_n;
  logic               run;
  logic [SCALE_W-1:0] mm, k_n, e, scale_n;
  logic [RW-1:0]      sh;
  logic               special;
  // the whole pipe moves together; bubbles travel with it
  assign en = ~io.out_valid | io.out_ready;
  assign io.in_ready = en;
  // stage 1: sign, special flags and two's-complement magnitude (only the low RW bits matter)
  always_ff @(posedge clk)
    if (reset) begin
      {v1, s1, z1, n1, u1, t1} <= '0;
    end else if (en) begin
      v1 <= io.in_valid;
      s1 <= io.in_data[NBITS-1];
      z1 <= ~io.in_data[NBITS-1] & ~|io.in_data[RW-1:0];
      n1 <= io.in_data[NBITS-1] & ~|io.in_data[RW-1:0];
      u1 <= io.in_data[NBITS-1] ? -io.in_data[RW-1:0] : io.in_data[RW-1:0];
      t1 <= io.in_tag;
    end
  // regime run length: count leading bits equal to the first regime bit
  always_comb begin
    run = 1'b1;
    m   = '0;
    for (int i = RW-1; i >= 0; i--) begin
      run = run & (u1[i] == u1[RW-1]);
      m   = m + MW'(run);
    end
  end
  assign w_n = (m == MW'(RW)) ? MW'(RW) : m + MW'(1);
  assign mm  = SCALE_W'(m);
  assign k_n = u1[RW-1] ? mm - SCALE_W'(1) : -mm;
  // stage 2: regime value k and regime width including terminator
  always_ff @(posedge clk)
    if (reset) begin
      {v2, s2, z2, n2, r2, k2, w2, t2} <= '0;
    end else if (en) begin
      v2 <= v1;
      s2 <= s1;
      z2 <= z1;
      n2 <= n1;
      r2 <= u1;
      k2 <= k_n;
      w2 <= w_n;
      t2 <= t1;
    end
  assign sh      = r2 << w2;
  assign e       = SCALE_W'(sh >> (RW - ES));
  assign scale_n = (k2 << ES) + e;
  assign special = z2 | n2;
  // stage 3: exponent and fraction from the regime-stripped word; specials force scale/frac to 0
  always_ff @(posedge clk)
    if (reset) begin
      io.out_valid <= 1'b0;
      io.out_sign  <= 1'b0;
      io.out_zero  <= 1'b0;
      io.out_inf   <= 1'b0;
      io.out_scale <= '0;
      io.out_frac  <= '0;
      io.out_abs   <= '0;
      io.out_tag   <= '0;
    end else if (en) begin
      io.out_valid <= v2;
      io.out_sign  <= s2;
      io.out_zero  <= z2;
      io.out_inf   <= n2;
      io.out_scale <= special ? '0 : scale_n;
      io.out_frac  <= special ? '0 : sh[RW-1-ES:2];
      io.out_abs   <= r2;
      io.out_tag   <= t2;
    end
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb_posit_decode_pipe: directed-vector bench for the pipelined posit decoder
module tb_posit_decode_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  posit_decode_pipe_if #(.NBITS(32), .ES(3), .TAG_W(8)) p32();
  posit_decode_pipe_if #(.NBITS(16), .ES(1), .TAG_W(8)) p16();
  posit_decode_pipe #(.NBITS(32), .ES(3), .TAG_W(8)) dut32 (.clk(clk), .reset(reset), .io(p32.slave));
  posit_decode_pipe #(.NBITS(16), .ES(1), .TAG_W(8)) dut16 (.clk(clk), .reset(reset), .io(p16.slave));
  typedef struct {
    logic [31:0] d;
    bit          s, z, n;
    int          sc;
    longint      fr, ab;
  } vec_t;
  vec_t v[11];
  vec_t w[4];
  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    v = '{
      '{32'h40000000, 0, 0, 0,    0, 0,          32'h40000000},
      '{32'h48000000, 0, 0, 0,    2, 0,          32'h48000000},
      '{32'hC0000000, 1, 0, 0,    0, 0,          32'h40000000},
      '{32'h00000000, 0, 1, 0,    0, 0,          0},
      '{32'h80000000, 1, 0, 1,    0, 0,          0},
      '{32'h7FFFFFFF, 0, 0, 0,  240, 0,          32'h7FFFFFFF},
      '{32'h00000001, 0, 0, 0, -240, 0,          1},
      '{32'h80000001, 1, 0, 0,  240, 0,          32'h7FFFFFFF},
      '{32'h41000000, 0, 0, 0,    0, 32'h1000000, 32'h41000000},
      '{32'h3C000000, 0, 0, 0,   -1, 0,          32'h3C000000},
      '{32'h7FFFFFFD, 0, 0, 0,  228, 0,          32'h7FFFFFFD}
    };
    w = '{
      '{32'h5000, 0, 0, 0,   1, 0, 32'h5000},
      '{32'h0001, 0, 0, 0, -28, 0, 1},
      '{32'h7FFF, 0, 0, 0,  28, 0, 32'h7FFF},
      '{32'hB000, 1, 0, 0,   1, 0, 32'h5000}
    };
    p32.in_valid = 0; p32.in_data = '0; p32.in_tag = '0; p32.out_ready = 1;
    p16.in_valid = 0; p16.in_data = '0; p16.in_tag = '0; p16.out_ready = 1;
    reset = 1;
    step();
    step();
    reset = 0;
    check("rst_out_valid", p32.out_valid, 0);
    check("rst_in_ready", p32.in_ready, 1);
    check("rst_scale", p32.out_scale, 0);
    check("rst_abs", p32.out_abs, 0);
    check("rst_tag", p32.out_tag, 0);
    check("rst16_out_valid", p16.out_valid, 0);
    for (int c = 0; c < 14; c++) begin
      if (c < 11) begin
        p32.in_valid = 1; p32.in_data = v[c].d; p32.in_tag = 8'(c);
      end else p32.in_valid = 0;
      #1;
      if (c < 3) check($sformatf("lat_valid_c%0d", c), p32.out_valid, 0);
      else begin
        check($sformatf("v%0d_valid", c-3), p32.out_valid, 1);
        check($sformatf("v%0d_sign", c-3), p32.out_sign, v[c-3].s);
        check($sformatf("v%0d_zero", c-3), p32.out_zero, v[c-3].z);
        check($sformatf("v%0d_inf", c-3), p32.out_inf, v[c-3].n);
        check($sformatf("v%0d_scale", c-3), p32.out_scale, v[c-3].sc);
        check($sformatf("v%0d_frac", c-3), p32.out_frac, v[c-3].fr);
        check($sformatf("v%0d_abs", c-3), p32.out_abs, v[c-3].ab);
        check($sformatf("v%0d_tag", c-3), p32.out_tag, c-3);
      end
      step();
    end
    begin
      int sent = 0;
      int got = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
        p32.out_ready = (c % 3 == 0);
        p32.in_valid = (sent < 5);
        p32.in_data = 32'h40000000 | (32'(sent + 1) << 8);
        p32.in_tag = 8'(sent + 1);
        #1;
        check($sformatf("bp_in_ready_c%0d", c), p32.in_ready, !p32.out_valid || p32.out_ready);
        if (p32.out_valid) begin
          check($sformatf("bp_tag_c%0d", c), p32.out_tag, got + 1);
          check($sformatf("bp_abs_c%0d", c), p32.out_abs, 32'h40000000 | (32'(got + 1) << 8));
        end
        if (p32.out_valid && p32.out_ready) got++;
        if (p32.in_valid && p32.in_ready) sent++;
        step();
      end
      check("bp_count", got, 5);
    end
    p32.in_valid = 0;
    p32.out_ready = 1;
    step();
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      p32.in_valid = 1; p32.in_data = 32'h48000000; p32.in_tag = 8'(8'hA0 + c);
      step();
    end
    p32.in_valid = 0;
    reset = 1;
    step();
    reset = 0;
    check("rs_out_valid", p32.out_valid, 0);
    check("rs_in_ready", p32.in_ready, 1);
    p32.in_valid = 1; p32.in_data = 32'h48000000; p32.in_tag = 8'h77;
    step();
    p32.in_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("rs_valid_c%0d", c), p32.out_valid, c == 3);
      if (c < 3) step();
    end
    check("rs_tag", p32.out_tag, 8'h77);
    check("rs_scale", p32.out_scale, 2);
    step();
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        p16.in_valid = 1; p16.in_data = w[c].d[15:0]; p16.in_tag = 8'(c);
      end else p16.in_valid = 0;
      #1;
      if (c >= 3) begin
        check($sformatf("p16_%0d_valid", c-3), p16.out_valid, 1);
        check($sformatf("p16_%0d_sign", c-3), p16.out_sign, w[c-3].s);
        check($sformatf("p16_%0d_scale", c-3), p16.out_scale, w[c-3].sc);
        check($sformatf("p16_%0d_frac", c-3), p16.out_frac, w[c-3].fr);
        check($sformatf("p16_%0d_abs", c-3), p16.out_abs, w[c-3].ab);
        check($sformatf("p16_%0d_tag", c-3), p16.out_tag, c-3);
      end
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/posit_decode_pipe.md
Name: posit_decode_pipe

Overview:
- Parametrised, pipelined posit decoder.
- Converts a standard posit(NBITS, ES) word into sign, zero/NaR flags, signed scale, fraction and the sign-stripped magnitude.
- Three register stages with a valid/ready stream handshake and a passthrough tag, so it drops in front of the posit add/mul datapaths in the PairHMM stream.
- Generalises the fixed ES=3 combinational extractor to any NBITS/ES; also adds a full standard regime decode, truncated-exponent handling and back-pressure.

Parameters:
- NBITS, 32, posit width; legal 8..32.
- ES, 3, exponent field width; legal 0..4, ES <= NBITS-3.
- TAG_W, 8, width of sideband tag carried alongside data.
- Derived (localparam): SCALE_W = $clog2((NBITS-1)<<ES)+1 (signed); FRAC_W = NBITS-ES-3.

Ports:
- clk, input, 1, clock; all state on rising edge.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, input word valid.
- in_ready, output, 1, decoder can accept this cycle.
- in_data, input, NBITS, posit word.
- in_tag, input, TAG_W, sideband tag.
- out_valid, output, 1, decoded result valid.
- out_ready, input, 1, consumer accepts result.
- out_sign, output, 1, posit sign bit.
- out_zero, output, 1, input == 0.
- out_inf, output, 1, input == NaR (1 followed by all zeros).
- out_scale, output, SCALE_W, signed k*2^ES + e.
- out_frac, output, FRAC_W, fraction bits, MSB-aligned, hidden bit excluded.
- out_abs, output, NBITS-1, magnitude bits u[NBITS-2:0].
- out_tag, output, TAG_W, tag of this result.

Behaviour:
- Reset (sync, active-high): all stage valid bits clear, so out_valid=0. All data outputs are 0. in_ready=1 on the first cycle after reset. Reset mid-operation discards all in-flight words; no partial result is ever emitted.
- Global advance: en = ~out_valid | out_ready; in_ready = en (combinational).
  - When en=1, every stage shifts by one. Stage-1 valid takes in_valid.
  - When en=0, all stages hold.
  - Bubbles are not squeezed.
- Latency: exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid with no stalls. Throughput is 1 word/cycle.
- Stage 1: register the word.
  - sign = in[NBITS-1]; nz = |in[NBITS-2:0].
  - zero = ~sign & ~nz; inf = sign & ~nz.
  - u = sign ? -in : in (two's complement, NBITS wide).
- Stage 2: regime decode on r = u[NBITS-2:0].
  - If r[MSB]=1: m = length of the ones run from the MSB; k = m-1.
  - Else: m = length of the zeros run; k = -m.
  - Regime width w = min(m+1, NBITS-1), which includes the terminator.
- Stage 3: shift r left by w.
  - Exponent e = top ES bits of the shifted word. Bits shifted in are zero, so a truncated exponent reads as zero-padded LSBs.
  - frac = next FRAC_W bits.
  - scale = (k <<< ES) + e, computed signed at SCALE_W bits.
- Special-value outputs:
  - zero / inf: scale and frac are 0 (forced).
  - out_sign is always the raw sign bit.
  - out_abs is u[NBITS-2:0] for all inputs.
- ES=0: the exponent field is absent; scale = k.
- All-ones regime (maxpos) and all-zeros-with-LSB regime (minpos) need no terminator; w caps at NBITS-1 and frac = 0.
- Simultaneous stall and new input: while in_ready=0 the input is not consumed, and the source must hold in_data/in_tag stable.
- out_tag is the tag presented with the same accepted input; ordering is strictly FIFO.

Test Plan:
- NBITS=32, ES=3, back-to-back 0x40000000, 0x48000000, 0xC0000000 with out_ready=1. Required responses, appearing on cycles 3, 4, 5:
  - 0x40000000: scale=0, frac=0, sign=0.
  - 0x48000000: scale=2, frac=0.
  - 0xC0000000: sign=1, scale=0, abs=0x40000000.
- Specials: 0x00000000 -> zero=1, inf=0, scale=0. 0x80000000 -> inf=1, zero=0, sign=1, scale=0, frac=0.
- Extremes: 0x7FFFFFFF -> scale=+240, frac=0. 0x00000001 -> scale=-240, frac=0. 0x80000001 (-maxpos) -> sign=1, scale=+240.
- Back-pressure: stream 5 tagged words (tags 1..5) while out_ready toggles 1,0,0,1,... Required:
  - in_ready mirrors ~out_valid|out_ready.
  - No loss or duplication; tags exit in order 1..5.
  - Outputs stay stable while stalled.
- Reset mid-stream: 3 words in flight, assert reset 1 cycle. Next cycle out_valid=0 and in_ready=1; the next accepted word emerges after exactly 3 cycles.
- Parameter sweep NBITS=16, ES=1: 0x5000 -> scale=1, frac=0. 0x0001 -> scale=-28. 0x7FFF -> scale=+28.
